// File: rtl/conv_requant_pack_pkg.sv
// Shared types and constants for the accumulator requantise/pack path.
// The top-level parameters default to the *_DEF values here so the typedefs line up.
package conv_requant_pack_pkg;
  localparam int ACC_W       = 32;
  localparam int PIX_W       = 8;
  localparam int LEAKY_NUM   = 13;
  localparam int LEAKY_SHIFT = 7;

  localparam int LANES_DEF   = 8;
  localparam int MULT_W_DEF  = 16;
  localparam int SHIFT_W_DEF = 5;
  localparam int RES_W_DEF   = ACC_W + MULT_W_DEF + 2;

  typedef logic [LANES_DEF*PIX_W-1:0] pix_word_t;

  typedef struct packed {
    logic [MULT_W_DEF-1:0]  mult;
    logic [SHIFT_W_DEF-1:0] shift;
    logic [PIX_W-1:0]       zp;
    logic                   leaky_en;
  } rq_cfg_t;

  // Clamp a wide signed result into the uint8 output range.
  function automatic logic [PIX_W-1:0] sat_u8(input logic signed [RES_W_DEF-1:0] r);
    if (r < 0)        return '0;
    else if (r > 255) return 8'hFF;
    else              return r[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/conv_requant_pack_if.sv
// Accumulator input, per-sample config and packed-word output of conv_requant_pack.
interface conv_requant_pack_if
  import conv_requant_pack_pkg::*;
#(
  parameter int NUM_LANES = LANES_DEF,
  parameter int MULT_W    = MULT_W_DEF,
  parameter int SHIFT_W   = SHIFT_W_DEF
);
  logic                          in_valid;
  logic signed [ACC_W-1:0]       in_data;
  logic                          in_last;
  logic [MULT_W-1:0]             cfg_mult;
  logic [SHIFT_W-1:0]            cfg_shift;
  logic [PIX_W-1:0]              cfg_zp;
  logic                          cfg_leaky_en;
  logic                          out_valid;
  logic [NUM_LANES*PIX_W-1:0]    out_data;
  logic                          out_ready;
  logic                          overflow;

  modport master (
    output in_valid, in_data, in_last, cfg_mult, cfg_shift, cfg_zp, cfg_leaky_en, out_ready,
    input  out_valid, out_data, overflow
  );
  modport slave (
    input  in_valid, in_data, in_last, cfg_mult, cfg_shift, cfg_zp, cfg_leaky_en, out_ready,
    output out_valid, out_data, overflow
  );
endinterface

// File: rtl/sync_word_fifo.sv
// Small synchronous FIFO; a push while full is accepted only if a pop frees a slot the same cycle.
module sync_word_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/conv_requant_pack.sv
// Leaky activation, fixed-point requantisation and uint8 saturation of PE accumulators,
// packed NUM_LANES channels per word into an output FIFO. Three register stages then the packer.
module conv_requant_pack
  import conv_requant_pack_pkg::*;
#(
  parameter int NUM_LANES  = LANES_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int MULT_W     = MULT_W_DEF,
  parameter int SHIFT_W    = SHIFT_W_DEF
) (
  input logic clk,
  input logic rst,
  conv_requant_pack_if.slave bus
);
  localparam int STAGES = 3;
  localparam int OUT_W  = NUM_LANES * PIX_W;
  localparam int PROD_W = ACC_W + MULT_W + 1;
  localparam int RES_W  = PROD_W + 1;
  localparam int LANE_W = $clog2(NUM_LANES);

  logic [STAGES:1] vld_pipe, last_pipe;

  logic signed [ACC_W-1:0]  s1_x, s2_a;
  rq_cfg_t                  s1_cfg, s2_cfg;
  logic signed [PROD_W-1:0] s3_q;
  logic [PIX_W-1:0]         s3_zp;

  logic signed [ACC_W+3:0]  x_m;
  logic signed [ACC_W-1:0]  act;
  logic signed [PROD_W-1:0] mult_s, prod, rnd, q;
  logic [SHIFT_W-1:0]       sh;
  logic signed [RES_W-1:0]  r;
  logic [PIX_W-1:0]         pix;

  // S1: leaky activation (x*13)>>>7, floor rounding for negatives
  always_comb begin
    x_m = 36'(s1_x) * 36'(LEAKY_NUM);
    act = (s1_cfg.leaky_en && s1_x < 0) ? ACC_W'(x_m >>> LEAKY_SHIFT) : s1_x;
  end

  // S2: multiply by unsigned scale, round-half-up, arithmetic shift
  always_comb begin
    sh     = s2_cfg.shift;
    mult_s = $signed({{(PROD_W-MULT_W){1'b0}}, s2_cfg.mult});
    prod   = PROD_W'(s2_a) * mult_s;
    rnd    = (sh != '0) ? (PROD_W'(1) <<< (sh - SHIFT_W'(1))) : '0;
    q      = (prod + rnd) >>> sh;
  end

  // S3: zero point and clamp
  always_comb begin
    r   = RES_W'(s3_q) + RES_W'($signed({1'b0, s3_zp}));
    pix = sat_u8(r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      s1_x      <= '0;
      s1_cfg    <= '0;
      s2_a      <= '0;
      s2_cfg    <= '0;
      s3_q      <= '0;
      s3_zp     <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], bus.in_valid};
      last_pipe <= {last_pipe[STAGES-1:1], bus.in_valid & bus.in_last};
      s1_x      <= bus.in_data;
      s1_cfg    <= '{mult: bus.cfg_mult, shift: bus.cfg_shift,
                     zp: bus.cfg_zp, leaky_en: bus.cfg_leaky_en};
      s2_a      <= act;
      s2_cfg    <= s1_cfg;
      s3_q      <= q;
      s3_zp     <= s2_cfg.zp;
    end
  end

  // Packer: the word is handed to the FIFO in the same cycle the closing byte arrives.
  logic [LANE_W-1:0] lane_cnt;
  logic [OUT_W-1:0]  word_q, word_nxt;
  logic              push, full, empty, drop, ovf_q;

  always_comb begin
    word_nxt = word_q;
    word_nxt[lane_cnt*PIX_W +: PIX_W] = pix;
    push = vld_pipe[STAGES] && (last_pipe[STAGES] || lane_cnt == LANE_W'(NUM_LANES-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      word_q   <= '0;
    end else if (push) begin
      lane_cnt <= '0;
      word_q   <= '0;
    end else if (vld_pipe[STAGES]) begin
      lane_cnt <= lane_cnt + LANE_W'(1);
      word_q   <= word_nxt;
    end
  end

  sync_word_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (word_nxt),
    .pop   (bus.out_ready),
    .dout  (bus.out_data),
    .full  (full),
    .empty (empty)
  );

  assign drop = push && full && !bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_q | drop;
  end

  assign bus.out_valid = !empty;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_conv_requant_pack.sv
// Directed bench: expected words queued at issue time, popped and compared by a monitor.
module tb_conv_requant_pack;
  import conv_requant_pack_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_requant_pack_if #(.NUM_LANES(8), .MULT_W(16), .SHIFT_W(5)) bus();

  conv_requant_pack #(.NUM_LANES(8), .FIFO_DEPTH(4), .MULT_W(16), .SHIFT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] sb [$];
  logic [63:0] exp_w;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", bus.out_data);
      end else begin
        exp_w = sb.pop_front();
        check("out_word", bus.out_data, exp_w);
      end
    end
  end

  task automatic set_cfg(input int mult, input int shift, input int zp, input int leaky);
    bus.cfg_mult     = 16'(mult);
    bus.cfg_shift    = 5'(shift);
    bus.cfg_zp       = 8'(zp);
    bus.cfg_leaky_en = 1'(leaky);
  endtask

  task automatic send(input int d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Single-sample word with in_last: expected byte in lane 0.
  task automatic one(input int d, input int mult, input int shift, input int zp,
                     input int leaky, input int exp_b);
    set_cfg(mult, shift, zp, leaky);
    sb.push_back({56'd0, 8'(exp_b)});
    send(d, 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({name, "_out_valid_low"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] w;
    logic [63:0] w1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;
    set_cfg(1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);

    // Full word of 0..7 and its output latency
    set_cfg(1, 0, 0, 0);
    sb.push_back(64'h0706050403020100);
    for (int i = 0; i < 8; i++) send(i, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check("lat_valid_early", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid_t4", 64'(bus.out_valid), 64'd1);
    drain("t_word");

    // Saturation, leaky, rounding, zero point
    one(1000, 1, 0, 0,   0, 255);
    one(-5,   1, 0, 0,   0, 0);
    one(-1000,1, 0, 128, 1, 26);
    one(300,  1, 2, 0,   0, 75);
    one(6,    1, 2, 0,   0, 2);
    one(-6,   1, 2, 10,  0, 9);
    one(100,  3, 1, 0,   0, 150);
    one(-128, 1, 0, 20,  1, 7);
    drain("t_math");

    // Partial flush, then next sample starts in lane 0
    set_cfg(1, 0, 0, 0);
    sb.push_back(64'h00000000001E140A);
    sb.push_back(64'h0000000000000005);
    send(10, 1'b0);
    send(20, 1'b0);
    send(30, 1'b1);
    send(5,  1'b1);
    drain("t_partial");

    // in_last on lane 7 must give a single push
    sb.push_back(64'h0807060504030201);
    for (int i = 1; i <= 8; i++) send(i, i == 8);
    drain("t_last7");

    // Backpressure: five words into a four-deep FIFO
    bus.out_ready = 1'b0;
    check("bp_ovf_before", 64'(bus.overflow), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(k*16 + j);
      if (k == 1) w1 = w;
      if (k <= 4) sb.push_back(w);
    end
    for (int k = 1; k <= 5; k++)
      for (int j = 0; j < 8; j++) send(k*16 + j, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("bp_overflow", 64'(bus.overflow), 64'd1);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check("bp_head", bus.out_data, w1);
    bus.out_ready = 1'b1;
    drain("t_bp");
    check("bp_overflow_sticky", 64'(bus.overflow), 64'd1);

    // Reset in the middle of a word
    set_cfg(1, 0, 0, 0);
    send(85, 1'b0);
    send(85, 1'b0);
    send(85, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_overflow", 64'(bus.overflow), 64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_data", bus.out_data, 64'd0);
    sb.push_back(64'h0807060504030201);
    for (int i = 1; i <= 8; i++) send(i, 1'b0);
    drain("t_rst");
    check("end_overflow", 64'(bus.overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
